// File: rtl/sd_host_reg_pkg.sv
// sd_host_reg_pkg: register offsets, bit positions and byte-lane helper
// shared by the SD host register bank, cpu_com and the engines.
package sd_host_reg_pkg;
  localparam logic [7:0] OFF_SYS_ADDR = 8'h00;
  localparam logic [7:0] OFF_BLK      = 8'h04;
  localparam logic [7:0] OFF_ARG      = 8'h08;
  localparam logic [7:0] OFF_XFER_CMD = 8'h0C;
  localparam logic [7:0] OFF_RSP0     = 8'h10;
  localparam logic [7:0] OFF_RSP1     = 8'h14;
  localparam logic [7:0] OFF_RSP2     = 8'h18;
  localparam logic [7:0] OFF_RSP3     = 8'h1C;
  localparam logic [7:0] OFF_PRESENT  = 8'h24;
  localparam logic [7:0] OFF_HOST_CTL = 8'h28;
  localparam logic [7:0] OFF_CLK_CTL  = 8'h2C;
  localparam logic [7:0] OFF_INT_STAT = 8'h30;
  localparam logic [7:0] OFF_INT_STEN = 8'h34;
  localparam logic [7:0] OFF_INT_SGEN = 8'h38;
  localparam int SOFT_RST_LSB   = 24;
  localparam int CMD_START_BYTE = 3;
  localparam int INT_ERR_SUM    = 15;
  localparam int INT_ERR_LSB    = 16;
  localparam logic [31:0] BLK_MASK      = 32'hFFFF_0FFF;
  localparam logic [31:0] XFER_CMD_MASK = 32'h3FFF_FFFF;
  localparam logic [31:0] CLK_CTL_MASK  = 32'h0000_FFFF;
  localparam logic [31:0] STAT_MASK     = 32'hFFFF_7FFF;
  typedef enum logic [1:0] {SR_ALL = 2'd0, SR_CMD = 2'd1, SR_DAT = 2'd2} soft_rst_e;
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/sd_host_int_ctrl.sv
// sd_host_int_ctrl: interrupt status (RW1C, set wins), status/signal enables
// and registered irq; bit 15 of status is the OR of the error half.
module sd_host_int_ctrl
  import sd_host_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_stat,
  input  logic        wr_sten,
  input  logic        wr_sgen,
  input  logic [31:0] wmask,
  input  logic [31:0] wr_data,
  input  logic [14:0] evt_normal,
  input  logic [15:0] evt_error,
  output logic [31:0] status,
  output logic [31:0] sten,
  output logic [31:0] sgen,
  output logic        irq
);
  logic [31:0] stat_q, stat_d, sten_q, sten_d, sgen_q, sgen_d, evt, w1c;
  logic irq_q, irq_d;
  assign evt = {evt_error, 1'b0, evt_normal};
  assign w1c = wr_stat ? (wr_data & wmask) : 32'h0;
  assign status = {stat_q[31:INT_ERR_LSB], |stat_q[31:INT_ERR_LSB], stat_q[INT_ERR_SUM-1:0]};
  assign sten = sten_q;
  assign sgen = sgen_q;
  assign irq = irq_q;
  always_comb begin
    stat_d = clr ? 32'h0 : ((stat_q & ~w1c) | (evt & sten_q)) & STAT_MASK;
    sten_d = clr ? 32'h0 : wr_sten ? ((sten_q & ~wmask) | (wr_data & wmask)) : sten_q;
    sgen_d = clr ? 32'h0 : wr_sgen ? ((sgen_q & ~wmask) | (wr_data & wmask)) : sgen_q;
    irq_d  = |(status & sgen_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_q <= '0;
      sten_q <= '0;
      sgen_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      sten_q <= sten_d;
      sgen_q <= sgen_d;
      irq_q  <= irq_d;
    end
endmodule

// File: rtl/sd_host_reg_bank.sv
// sd_host_reg_bank: SD host standard register subset behind cpu_com;
// single-access req/ack, command-start pulse and self-clearing soft resets.
module sd_host_reg_bank
  import sd_host_reg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        byte_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack,
  input  logic              rsp_valid,
  input  logic [127:0]      rsp_data,
  input  logic [31:0]       present_state,
  input  logic [14:0]       evt_normal,
  input  logic [15:0]       evt_error,
  input  logic [2:0]        rst_done,
  output logic [31:0]       sys_addr,
  output logic [31:0]       blk_size_cnt,
  output logic [31:0]       argument,
  output logic [31:0]       xfer_cmd,
  output logic [31:0]       host_ctl,
  output logic [31:0]       clk_ctl,
  output logic              cmd_start,
  output logic [2:0]        soft_rst,
  output logic              irq
);
  logic ack_q, ack_d, cmd_start_q, cmd_start_d, acc, wr, clr, unused_addr;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [31:0] sys_addr_q, sys_addr_d, blk_q, blk_d, arg_q, arg_d, xfer_cmd_q, xfer_cmd_d;
  logic [31:0] host_ctl_q, host_ctl_d, clk_ctl_q, clk_ctl_d, m, rd_mux, int_stat, int_sten, int_sgen;
  logic [127:0] rsp_q, rsp_d;
  logic [2:0] soft_rst_q, soft_rst_d;
  logic [7:0] off;
  assign acc = req & ~ack_q;
  assign wr = acc & wr_en;
  assign clr = soft_rst_q[SR_ALL];
  assign off = {addr[7:2], 2'b00};
  assign unused_addr = ^addr[1:0];
  assign m = be_mask(byte_en);
  function automatic logic [31:0] upd(input logic [31:0] q, input logic hit, input logic [31:0] keep);
    return clr ? 32'h0 : hit ? (((q & ~m) | (wr_data & m)) & keep) : q;
  endfunction
  sd_host_int_ctrl u_int (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_stat(wr && off == OFF_INT_STAT),
    .wr_sten(wr && off == OFF_INT_STEN),
    .wr_sgen(wr && off == OFF_INT_SGEN),
    .wmask(m), .wr_data(wr_data), .evt_normal(evt_normal), .evt_error(evt_error),
    .status(int_stat), .sten(int_sten), .sgen(int_sgen), .irq(irq)
  );
  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_SYS_ADDR: rd_mux = sys_addr_q;
      OFF_BLK:      rd_mux = blk_q;
      OFF_ARG:      rd_mux = arg_q;
      OFF_XFER_CMD: rd_mux = xfer_cmd_q;
      OFF_RSP0:     rd_mux = rsp_q[31:0];
      OFF_RSP1:     rd_mux = rsp_q[63:32];
      OFF_RSP2:     rd_mux = rsp_q[95:64];
      OFF_RSP3:     rd_mux = rsp_q[127:96];
      OFF_PRESENT:  rd_mux = present_state;
      OFF_HOST_CTL: rd_mux = host_ctl_q;
      OFF_CLK_CTL:  rd_mux = {5'b0, soft_rst_q, 8'b0, clk_ctl_q[15:0]};
      OFF_INT_STAT: rd_mux = int_stat;
      OFF_INT_STEN: rd_mux = int_sten;
      OFF_INT_SGEN: rd_mux = int_sgen;
      default:      rd_mux = 32'h0;
    endcase
  end
  always_comb begin
    sys_addr_d  = upd(sys_addr_q, wr && off == OFF_SYS_ADDR, '1);
    blk_d       = upd(blk_q, wr && off == OFF_BLK, BLK_MASK);
    arg_d       = upd(arg_q, wr && off == OFF_ARG, '1);
    xfer_cmd_d  = upd(xfer_cmd_q, wr && off == OFF_XFER_CMD, XFER_CMD_MASK);
    host_ctl_d  = upd(host_ctl_q, wr && off == OFF_HOST_CTL, '1);
    clk_ctl_d   = upd(clk_ctl_q, wr && off == OFF_CLK_CTL, CLK_CTL_MASK);
    rsp_d       = rsp_valid ? rsp_data : rsp_q;
    // a fresh set wins over a same-cycle completion report
    soft_rst_d  = (soft_rst_q & ~rst_done) |
                  ((wr && off == OFF_CLK_CTL && byte_en[3]) ? wr_data[SOFT_RST_LSB+:3] : 3'b0);
    cmd_start_d = wr && off == OFF_XFER_CMD && byte_en[CMD_START_BYTE];
    ack_d       = acc;
    rd_data_d   = (acc && !wr_en) ? rd_mux : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sys_addr_q  <= '0;
      blk_q       <= '0;
      arg_q       <= '0;
      xfer_cmd_q  <= '0;
      host_ctl_q  <= '0;
      clk_ctl_q   <= '0;
      rsp_q       <= '0;
      soft_rst_q  <= '0;
      cmd_start_q <= 1'b0;
      ack_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      sys_addr_q  <= sys_addr_d;
      blk_q       <= blk_d;
      arg_q       <= arg_d;
      xfer_cmd_q  <= xfer_cmd_d;
      host_ctl_q  <= host_ctl_d;
      clk_ctl_q   <= clk_ctl_d;
      rsp_q       <= rsp_d;
      soft_rst_q  <= soft_rst_d;
      cmd_start_q <= cmd_start_d;
      ack_q       <= ack_d;
      rd_data_q   <= rd_data_d;
    end
  assign rd_data      = rd_data_q;
  assign ack          = ack_q;
  assign sys_addr     = sys_addr_q;
  assign blk_size_cnt = blk_q;
  assign argument     = arg_q;
  assign xfer_cmd     = xfer_cmd_q;
  assign host_ctl     = host_ctl_q;
  assign clk_ctl      = clk_ctl_q;
  assign cmd_start    = cmd_start_q;
  assign soft_rst     = soft_rst_q;
endmodule

// File: tb/tb_sd_host_reg_bank.sv
// tb_sd_host_reg_bank: directed scenario tasks with hand-computed expectations.
module tb_sd_host_reg_bank;
  logic clk = 0, rst_n = 0, req = 0, wr_en = 0, rsp_valid = 0;
  logic [7:0] addr = 0;
  logic [3:0] byte_en = 0;
  logic [31:0] wr_data = 0, present_state = 0;
  logic [127:0] rsp_data = 0;
  logic [14:0] evt_normal = 0;
  logic [15:0] evt_error = 0;
  logic [2:0] rst_done = 0;
  logic [31:0] rd_data, sys_addr, blk_size_cnt, argument, xfer_cmd, host_ctl, clk_ctl;
  logic ack, cmd_start, irq;
  logic [2:0] soft_rst;
  int passed = 0, total = 0, cs_cnt = 0;

  sd_host_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_en(wr_en), .addr(addr), .byte_en(byte_en),
    .wr_data(wr_data), .rd_data(rd_data), .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .present_state(present_state), .evt_normal(evt_normal), .evt_error(evt_error),
    .rst_done(rst_done), .sys_addr(sys_addr), .blk_size_cnt(blk_size_cnt), .argument(argument),
    .xfer_cmd(xfer_cmd), .host_ctl(host_ctl), .clk_ctl(clk_ctl), .cmd_start(cmd_start),
    .soft_rst(soft_rst), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (cmd_start === 1'b1) cs_cnt++;

  task automatic xact(input logic w, input logic [7:0] a, input logic [3:0] be,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    @(negedge clk);
    req = 1; wr_en = w; addr = a; byte_en = be; wr_data = d;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (ack === 1'b1) break;
    end
    rd = rd_data;
    total++;
    if (ack !== 1'b1) $display("FAIL ack_timeout addr=%h got ack=%b want 1", a, ack);
    else passed++;
    @(negedge clk);
    req = 0; wr_en = 0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] r;
    int l;
    xact(1'b1, a, be, d, r, l);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    int l;
    xact(1'b0, a, 4'h0, 32'h0, d, l);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic [7:0] addrs [3] = '{8'h00, 8'h30, 8'hFC};
    int l;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ack, irq, cmd_start, soft_rst, rd_data, sys_addr, xfer_cmd, clk_ctl} !== '0)
      $display("FAIL reset_outputs got %b/%b/%b/%b/%h want all zero", ack, irq, cmd_start, soft_rst, rd_data);
    else passed++;
    @(negedge clk) rst_n = 1;
    foreach (addrs[i]) begin
      xact(1'b0, addrs[i], 4'h0, 32'h0, r, l);
      total++;
      if (r !== 32'h0) $display("FAIL reset_read_%h got %h want 0", addrs[i], r); else passed++;
      total++;
      if (l !== 1) $display("FAIL ack_latency_%h got %0d want 1", addrs[i], l); else passed++;
      @(posedge clk); #1;
      total++;
      if (ack !== 1'b0) $display("FAIL ack_single_pulse_%h got %b want 0", addrs[i], ack); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] seen;
    @(negedge clk);
    req = 1; wr_en = 0; addr = 8'h00;
    for (int i = 3; i >= 0; i--) begin
      @(posedge clk); #1;
      seen[i] = ack;
    end
    @(negedge clk) req = 0;
    total++;
    if (seen !== 4'b1010) $display("FAIL back_to_back_ack got %b want 1010", seen); else passed++;
  endtask

  task automatic test_byte_en;
    logic [31:0] r;
    wr_reg(8'h08, 4'b0101, 32'hDEADBEEF);
    rd_reg(8'h08, r);
    total++;
    if (r !== 32'h00AD00EF) $display("FAIL arg_byte_en got %h want 00ad00ef", r); else passed++;
    total++;
    if (argument !== 32'h00AD00EF) $display("FAIL arg_port got %h want 00ad00ef", argument); else passed++;
    wr_reg(8'h04, 4'hF, 32'hFFFFFFFF);
    rd_reg(8'h04, r);
    total++;
    if (r !== 32'hFFFF0FFF) $display("FAIL blk_reserved got %h want ffff0fff", r); else passed++;
  endtask

  task automatic test_interrupt;
    logic [31:0] r;
    wr_reg(8'h34, 4'hF, 32'hFFFF7FFF);
    wr_reg(8'h38, 4'hF, 32'h00000001);
    evt_normal = 15'h0001;
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_registered got %b want 0", irq); else passed++;
    @(negedge clk) evt_normal = 0;
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) $display("FAIL irq_set got %b want 1", irq); else passed++;
    rd_reg(8'h30, r);
    total++;
    if (r !== 32'h1) $display("FAIL stat_set got %h want 00000001", r); else passed++;
    wr_reg(8'h30, 4'b0010, 32'h00000001);
    rd_reg(8'h30, r);
    total++;
    if (r !== 32'h1) $display("FAIL w1c_disabled_lane got %h want 00000001", r); else passed++;
    wr_reg(8'h30, 4'b0001, 32'h00000001);
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq); else passed++;
    rd_reg(8'h30, r);
    total++;
    if (r !== 32'h0) $display("FAIL w1c_clear got %h want 0", r); else passed++;
  endtask

  task automatic test_set_priority;
    logic [31:0] r;
    @(negedge clk);
    req = 1; wr_en = 1; addr = 8'h30; byte_en = 4'hF; wr_data = 32'h00040000; evt_error = 16'h0004;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b1) $display("FAIL prio_ack got %b want 1", ack); else passed++;
    @(negedge clk);
    req = 0; wr_en = 0; evt_error = 0;
    rd_reg(8'h30, r);
    total++;
    if (r !== 32'h00048000) $display("FAIL set_beats_w1c got %h want 00048000", r); else passed++;
    wr_reg(8'h38, 4'hF, 32'h00008000);
    @(posedge clk); #1;
    total++;
    if (irq !== 1'b1) $display("FAIL irq_err_summary got %b want 1", irq); else passed++;
    wr_reg(8'h30, 4'b0100, 32'h00040000);
    rd_reg(8'h30, r);
    total++;
    if (r !== 32'h0) $display("FAIL err_clear got %h want 0", r); else passed++;
  endtask

  task automatic test_cmd_start;
    logic [31:0] r;
    int c0;
    c0 = cs_cnt;
    wr_reg(8'h0C, 4'hF, 32'h1A3B0012);
    @(posedge clk); #1;
    total++;
    if (cs_cnt - c0 !== 1) $display("FAIL cmd_start_pulse got %0d want 1", cs_cnt - c0); else passed++;
    total++;
    if (xfer_cmd !== 32'h1A3B0012) $display("FAIL xfer_cmd got %h want 1a3b0012", xfer_cmd); else passed++;
    c0 = cs_cnt;
    wr_reg(8'h0C, 4'b0011, 32'hFFFF0099);
    @(posedge clk); #1;
    total++;
    if (cs_cnt - c0 !== 0) $display("FAIL cmd_start_no_pulse got %0d want 0", cs_cnt - c0); else passed++;
    rd_reg(8'h0C, r);
    total++;
    if (r !== 32'h1A3B0099) $display("FAIL xfer_low_bytes got %h want 1a3b0099", r); else passed++;
  endtask

  task automatic test_response;
    logic [31:0] r;
    present_state = 32'hA5A50F0F;
    rd_reg(8'h24, r);
    total++;
    if (r !== 32'hA5A50F0F) $display("FAIL present_state got %h want a5a50f0f", r); else passed++;
    rsp_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    rsp_valid = 1;
    @(negedge clk) rsp_valid = 0;
    rd_reg(8'h14, r);
    total++;
    if (r !== 32'h11111111) $display("FAIL rsp_word1 got %h want 11111111", r); else passed++;
    @(negedge clk);
    req = 1; wr_en = 0; addr = 8'h10; rsp_data = {4{32'hABCD1234}}; rsp_valid = 1;
    @(posedge clk); #1;
    r = rd_data;
    @(negedge clk);
    req = 0; rsp_valid = 0;
    total++;
    if (r !== 32'h00000000) $display("FAIL rsp_same_cycle_old got %h want 00000000", r); else passed++;
    rd_reg(8'h10, r);
    total++;
    if (r !== 32'hABCD1234) $display("FAIL rsp_word0_new got %h want abcd1234", r); else passed++;
  endtask

  task automatic test_soft_reset;
    logic [31:0] r;
    logic [7:0] rw [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h28, 8'h2C, 8'h34, 8'h38};
    wr_reg(8'h2C, 4'hF, 32'h02001234);
    total++;
    if (soft_rst !== 3'b010) $display("FAIL soft_rst_cmd got %b want 010", soft_rst); else passed++;
    rd_reg(8'h2C, r);
    total++;
    if (r !== 32'h02001234) $display("FAIL clk_ctl_read got %h want 02001234", r); else passed++;
    rst_done = 3'b010;
    @(negedge clk) rst_done = 0;
    total++;
    if (soft_rst !== 3'b000) $display("FAIL soft_rst_done got %b want 000", soft_rst); else passed++;
    wr_reg(8'h00, 4'hF, 32'h12345678);
    wr_reg(8'h28, 4'hF, 32'h0000CAFE);
    wr_reg(8'h2C, 4'b1000, 32'h01000000);
    total++;
    if (soft_rst !== 3'b001) $display("FAIL soft_rst_all got %b want 001", soft_rst); else passed++;
    rst_done = 3'b001;
    @(negedge clk) rst_done = 0;
    foreach (rw[i]) begin
      rd_reg(rw[i], r);
      total++;
      if (r !== 32'h0) $display("FAIL soft_all_clear_%h got %h want 0", rw[i], r); else passed++;
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    req = 1; wr_en = 0; addr = 8'h00;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b1) $display("FAIL async_pre_ack got %b want 1", ack); else passed++;
    #1 rst_n = 0;
    #1;
    total++;
    if (ack !== 1'b0) $display("FAIL async_reset_ack got %b want 0", ack); else passed++;
    @(negedge clk);
    req = 0; rst_n = 1;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_byte_en;
    test_interrupt;
    test_set_priority;
    test_cmd_start;
    test_response;
    test_soft_reset;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sd_host_reg_bank.md
Name: sd_host_reg_bank

Overview:
- Register file directly downstream of cpu_com in the SD host REG block.
- cpu_com issues a decoded single-access request (address, byte enables, write data); this block performs the access against the SD host standard register subset and returns read data plus acknowledge.
- Also holds the interrupt status/enable logic, the command-start pulse and the self-clearing software-reset bits that feed the command/data engines.

Parameters:
- ADDR_W, 8, register offset width (0x00-0xFF map)
- DATA_W, 32, access data width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request from cpu_com, held until ack
- wr_en  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  register offset, 32-bit aligned (addr[1:0] ignored)
- byte_en  in  4  byte lanes for write; ignored on read
- wr_data  in  DATA_W  write data
- rd_data  out  DATA_W  read data, valid while ack=1
- ack  out  1  one-cycle access-complete strobe
- rsp_valid  in  1  engine loads response registers this cycle
- rsp_data  in  128  command response, words 0-3
- present_state  in  32  live status, read-only at 0x24
- evt_normal  in  15  normal interrupt event pulses (bits 14:0)
- evt_error  in  16  error interrupt event pulses
- rst_done  in  3  engine reports that the matching software reset is complete
- sys_addr, blk_size_cnt, argument, xfer_cmd, host_ctl, clk_ctl  out  32 each  register contents to the engines
- cmd_start  out  1  one-cycle pulse, command issued
- soft_rst  out  3  software reset bits {DAT, CMD, ALL}
- irq  out  1  interrupt to CPU

Behaviour:
- Reset: all registers and outputs are 0; ack=0, rd_data=0, cmd_start=0, irq=0.
- Handshake: an access is accepted on a clk edge where req=1 and ack=0. ack=1 and rd_data are registered on that same edge. ack is high for exactly one cycle. With req held high, accesses complete every 2 cycles. ack=1 on writes with rd_data=0.
- Register map, by offset:
  - 0x00: sys_addr, RW.
  - 0x04: block size [11:0] and block count [31:16], RW. Bits [15:12] read 0.
  - 0x08: argument, RW.
  - 0x0C: transfer mode [15:0] and command [29:16], RW. A write with byte_en[3]=1 pulses cmd_start for one cycle, coincident with ack.
  - 0x10-0x1C: response words 0-3, RO, loaded from rsp_data when rsp_valid=1.
  - 0x24: present_state, RO, passthrough sampled at access.
  - 0x28: host_ctl, RW.
  - 0x2C: clk_ctl [15:0] RW. soft_rst at [26:24]: writing 1 sets a bit; bit n clears when rst_done[n]=1; writing 0 has no effect.
  - 0x30: normal interrupt status [14:0] and error interrupt status [31:16], RW1C. Bit 15 = OR of error status, read-only.
  - 0x34: status enable, RW.
  - 0x38: signal enable, RW.
  - Any other offset: read 0, write ignored, ack still returned.
- Byte enables: only enabled bytes are updated; RW1C only clears bits inside enabled bytes.
- Status set: a bit is set when its evt pulse = 1 and the matching status-enable bit = 1. Set has priority over a same-cycle W1C. Clearing a status-enable bit does not clear status already latched.
- irq is registered: irq = |(status[31:0] & signal_en[31:0]), bit 15 included. It updates one cycle after status changes.
- soft_rst[0] (ALL) set: at the next edge, clear every RW/RW1C register except soft_rst itself. No access in flight is dropped.
- rsp_valid coincides with a read of 0x10-0x1C: the read returns the old value.
- rst_n asserted mid-access: ack and all state clear immediately. cpu_com must re-issue the access.

Decomposition:
- Package sd_host_reg_pkg holds register offset constants, the bit positions for soft_rst and cmd_start, and interrupt bit indices, all shared with cpu_com and the engines.
- One natural sub-module: sd_host_int_ctrl, containing the status/enable/signal registers, W1C/set priority and irq generation.

Test Plan:
- Reset, then read 0x00, 0x30 and 0xFC -> rd_data=0, ack is a single pulse one cycle after req.
- Write 0x08 = 0xDEADBEEF with byte_en=4'b0101, then read -> 0x00AD00EF.
- Write 0x34=0xFFFF7FFF and 0x38=0x00000001, pulse evt_normal[0] -> 0x30 reads 0x00000001 and irq=1 the next cycle. Write 0x30=0x1 -> status 0, irq=0.
- Same-cycle evt_error[2] and W1C of bit 18 -> bit 18 remains set and bit 15 reads 1.
- Write 0x0C=0x1A3B0012 with byte_en=4'b1111 -> cmd_start pulses once, xfer_cmd=0x1A3B0012. Repeat with byte_en=4'b0011 -> no pulse.
- Write 0x2C bit 25 -> soft_rst=3'b010 until rst_done[1] pulses, then 0. Write bit 24 -> all RW registers read 0 afterwards.
